// File: rtl/acc_drain_pkg.sv
// Shared widths, FSM states and the requantization helper for the accumulator drain.
package raven_pe_pkg;

  localparam int ROWS   = 8;
  localparam int ACC_BW = 32;
  localparam int OUT_BW = 16;
  localparam int SH_W   = $clog2(ACC_BW);
  localparam int IDX_W  = $clog2(ROWS);

  localparam logic signed [ACC_BW-1:0] OUT_MAX =
    {{(ACC_BW-OUT_BW+1){1'b0}}, {(OUT_BW-1){1'b1}}};
  localparam logic signed [ACC_BW-1:0] OUT_MIN =
    {{(ACC_BW-OUT_BW+1){1'b1}}, {(OUT_BW-1){1'b0}}};

  typedef enum logic {
    IDLE  = 1'b0,
    DRAIN = 1'b1
  } drain_state_t;

  typedef struct packed {
    logic              sat;
    logic [OUT_BW-1:0] data;
  } rq_t;

  // Floor shift (arithmetic), shift clamped to ACC_BW-1, then clip to the signed OUT_BW range.
  function automatic rq_t sat_shift(input logic signed [ACC_BW-1:0] acc,
                                    input logic [SH_W-1:0]          sh);
    logic [SH_W-1:0]          sh_c;
    logic signed [ACC_BW-1:0] v;
    rq_t                      r;
    sh_c = (sh > SH_W'(ACC_BW-1)) ? SH_W'(ACC_BW-1) : sh;
    v    = acc >>> sh_c;
    if (v > OUT_MAX) begin
      r.sat  = 1'b1;
      r.data = OUT_MAX[OUT_BW-1:0];
    end else if (v < OUT_MIN) begin
      r.sat  = 1'b1;
      r.data = OUT_MIN[OUT_BW-1:0];
    end else begin
      r.sat  = 1'b0;
      r.data = v[OUT_BW-1:0];
    end
    return r;
  endfunction

endpackage

// File: rtl/acc_drain_if.sv
// Output word stream from the accumulator drain to the writeback path.
interface acc_drain_if;
  import raven_pe_pkg::*;

  // Handshake: a word moves when out_valid_o & out_ready_i at a rising clk edge.
  // Once valid is high, data/idx/last hold and valid stays high until that transfer.
  logic              out_valid_o;
  logic              out_ready_i;
  logic [OUT_BW-1:0] out_data_o;
  logic [IDX_W-1:0]  out_idx_o;
  logic              out_last_o;

  modport master (
    output out_valid_o, out_data_o, out_idx_o, out_last_o,
    input  out_ready_i
  );

  modport slave (
    input  out_valid_o, out_data_o, out_idx_o, out_last_o,
    output out_ready_i
  );

endinterface

// File: rtl/acc_drain_requant.sv
// Combinational requantizer: arithmetic shift, shift clamp and saturation of one accumulator.
module acc_drain_requant
  import raven_pe_pkg::*;
(
  input  logic signed [ACC_BW-1:0] acc_i,
  input  logic [SH_W-1:0]          shift_i,
  output logic [OUT_BW-1:0]        data_o,
  output logic                     sat_o
);

  rq_t rq;

  assign rq     = sat_shift(acc_i, shift_i);
  assign data_o = rq.data;
  assign sat_o  = rq.sat;

endmodule

// File: rtl/acc_drain.sv
// Snapshots ROWS accumulators on cap_i and streams requantized words one per cycle.
module acc_drain
  import raven_pe_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   cap_i,
  input  logic [ROWS*ACC_BW-1:0] acc_i,
  input  logic [SH_W-1:0]        shift_i,
  input  logic                   clr_i,
  output logic                   busy_o,
  output logic                   ovf_o,
  output logic                   sat_o,
  output drain_state_t           dbg_state_o,
  acc_drain_if.master            out
);

  drain_state_t             state_q, state_d;
  logic signed [ACC_BW-1:0] buf_q [ROWS];
  logic [SH_W-1:0]          shift_q;
  logic [IDX_W-1:0]         idx_q, idx_d;
  logic                     ovf_q, sat_q;
  logic                     load;
  logic                     xfer;
  logic                     at_last;
  logic [OUT_BW-1:0]        rq_data;
  logic                     rq_sat;

  assign xfer    = (state_q == DRAIN) && out.out_ready_i;
  assign at_last = (idx_q == IDX_W'(ROWS-1));

  acc_drain_requant u_requant (
    .acc_i   (buf_q[idx_q]),
    .shift_i (shift_q),
    .data_o  (rq_data),
    .sat_o   (rq_sat)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    load    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (cap_i) begin
          load    = 1'b1;
          idx_d   = '0;
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (xfer) begin
          if (!at_last) begin
            idx_d = idx_q + 1'b1;
          end else if (cap_i) begin
            // Back-to-back snapshot: reload on the final transfer so there is no bubble.
            load  = 1'b1;
            idx_d = '0;
          end else begin
            idx_d   = '0;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      shift_q <= '0;
      ovf_q   <= 1'b0;
      sat_q   <= 1'b0;
      for (int r = 0; r < ROWS; r++) buf_q[r] <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      if (load) begin
        shift_q <= shift_i;
        for (int r = 0; r < ROWS; r++) buf_q[r] <= acc_i[r*ACC_BW +: ACC_BW];
      end
      // A set event in the same cycle as clr_i takes priority.
      if ((state_q == DRAIN) && cap_i && !(xfer && at_last)) ovf_q <= 1'b1;
      else if (clr_i)                                        ovf_q <= 1'b0;
      if (xfer && rq_sat)  sat_q <= 1'b1;
      else if (clr_i)      sat_q <= 1'b0;
    end
  end

  assign out.out_valid_o = (state_q == DRAIN);
  assign out.out_data_o  = (state_q == DRAIN) ? rq_data : '0;
  assign out.out_idx_o   = idx_q;
  assign out.out_last_o  = (state_q == DRAIN) && at_last;
  assign busy_o          = (state_q == DRAIN);
  assign ovf_o           = ovf_q;
  assign sat_o           = sat_q;
  assign dbg_state_o     = state_q;

endmodule

// File: tb/tb_acc_drain.sv
// Directed bench for acc_drain: streaming order, requantization, stalls, overlap captures and reset.
module tb_acc_drain;
  import raven_pe_pkg::*;

  localparam int EW = 1 + IDX_W + OUT_BW;

  logic                   clk;
  logic                   rst;
  logic                   cap_i;
  logic [ROWS*ACC_BW-1:0] acc_i;
  logic [SH_W-1:0]        shift_i;
  logic                   clr_i;
  logic                   busy_o;
  logic                   ovf_o;
  logic                   sat_o;
  drain_state_t           dbg_state_o;

  acc_drain_if u_if ();

  acc_drain dut (
    .clk         (clk),
    .rst         (rst),
    .cap_i       (cap_i),
    .acc_i       (acc_i),
    .shift_i     (shift_i),
    .clr_i       (clr_i),
    .busy_o      (busy_o),
    .ovf_o       (ovf_o),
    .sat_o       (sat_o),
    .dbg_state_o (dbg_state_o),
    .out         (u_if.master)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int n_xfer   = 0;
  logic [EW-1:0] exp_q[$];

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [EW-1:0] mk(input logic last, input int idx, input logic [OUT_BW-1:0] d);
    logic [IDX_W-1:0] i;
    i = idx[IDX_W-1:0];
    return {last, i, d};
  endfunction

  // driver tasks
  task automatic set_row(input int r, input logic [ACC_BW-1:0] v);
    acc_i[r*ACC_BW +: ACC_BW] = v;
  endtask

  // Scoreboard sample of the current cycle, then advance one clock.
  task automatic cycle();
    logic [EW-1:0] e;
    if (u_if.out_valid_o && u_if.out_ready_i) begin
      n_xfer++;
      if (exp_q.size() == 0) begin
        check_eq("xfer_unexpected", 1, 0);
      end else begin
        e = exp_q.pop_front();
        check_eq("xfer_word", {u_if.out_last_o, u_if.out_idx_o, u_if.out_data_o}, e);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input string tag, input int budget, output int cycles);
    cycles = 0;
    while (exp_q.size() != 0 && cycles < budget) begin
      cycle();
      cycles++;
    end
    check_eq({tag, "_drained"}, exp_q.size(), 0);
  endtask

  task automatic capture(input logic [SH_W-1:0] sh);
    shift_i = sh;
    cap_i   = 1'b1;
    cycle();
    cap_i   = 1'b0;
  endtask

  int cyc;
  int x0;
  logic pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
  logic [EW-1:0] held;

  initial begin
    rst = 1'b1; cap_i = 1'b0; acc_i = '0; shift_i = '0; clr_i = 1'b0;
    u_if.out_ready_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    check_eq("rst_valid", u_if.out_valid_o, 0);
    check_eq("rst_busy", busy_o, 0);
    check_eq("rst_data", u_if.out_data_o, 0);
    check_eq("rst_idx", u_if.out_idx_o, 0);
    check_eq("rst_last", u_if.out_last_o, 0);
    check_eq("rst_flags", {ovf_o, sat_o}, 0);
    check_eq("rst_state", dbg_state_o, IDLE);

    // 1: shift 0, acc = 0..7, ready always high
    for (int r = 0; r < ROWS; r++) set_row(r, ACC_BW'(r));
    u_if.out_ready_i = 1'b1;
    capture(5'd0);
    check_eq("t1_valid_lat1", u_if.out_valid_o, 1);
    check_eq("t1_state", dbg_state_o, DRAIN);
    for (int r = 0; r < ROWS; r++) exp_q.push_back(mk(r == 7, r, OUT_BW'(r)));
    drain("t1", 20, cyc);
    check_eq("t1_cycles", cyc, 8);
    check_eq("t1_busy_end", busy_o, 0);
    check_eq("t1_valid_end", u_if.out_valid_o, 0);

    // 2: shift 4 with positive and negative (floor) values
    acc_i = '0;
    set_row(0, 32'h0001_2345);
    set_row(1, 32'hFFFF_FFEF);
    capture(5'd4);
    exp_q.push_back(mk(0, 0, 16'h1234));
    exp_q.push_back(mk(0, 1, 16'hFFFE));
    for (int r = 2; r < ROWS; r++) exp_q.push_back(mk(r == 7, r, 16'h0000));
    drain("t2", 20, cyc);
    check_eq("t2_sat_clear", sat_o, 0);

    // 3: saturation both directions; sat only on transfer; set beats clr
    acc_i = '0;
    set_row(0, 32'h7FFF_0000);
    set_row(1, 32'h8000_0000);
    u_if.out_ready_i = 1'b0;
    capture(5'd0);
    cycle();
    check_eq("t3_sat_stall", sat_o, 0);
    check_eq("t3_stall_data", u_if.out_data_o, 16'h7FFF);
    u_if.out_ready_i = 1'b1;
    exp_q.push_back(mk(0, 0, 16'h7FFF));
    exp_q.push_back(mk(0, 1, 16'h8000));
    for (int r = 2; r < ROWS; r++) exp_q.push_back(mk(r == 7, r, 16'h0000));
    cycle();
    check_eq("t3_sat_set", sat_o, 1);
    clr_i = 1'b1;
    cycle();
    clr_i = 1'b0;
    check_eq("t3_set_beats_clr", sat_o, 1);
    drain("t3", 20, cyc);
    clr_i = 1'b1;
    cycle();
    clr_i = 1'b0;
    check_eq("t3_clr", sat_o, 0);

    // 4: ready pattern 1,0,0,1 -> stalls hold the word
    for (int r = 0; r < ROWS; r++) set_row(r, ACC_BW'(16 * r));
    x0 = n_xfer;
    u_if.out_ready_i = 1'b1;
    capture(5'd4);
    for (int r = 0; r < ROWS; r++) exp_q.push_back(mk(r == 7, r, OUT_BW'(r)));
    cyc = 0;
    while (exp_q.size() != 0 && cyc < 40) begin
      u_if.out_ready_i = pat[cyc % 4];
      held = {u_if.out_last_o, u_if.out_idx_o, u_if.out_data_o};
      cycle();
      if (!pat[cyc % 4]) begin
        check_eq("t4_hold_word", {u_if.out_last_o, u_if.out_idx_o, u_if.out_data_o}, held);
        check_eq("t4_hold_valid", u_if.out_valid_o, 1);
      end
      cyc++;
    end
    check_eq("t4_drained", exp_q.size(), 0);
    check_eq("t4_xfers", n_xfer - x0, 8);
    check_eq("t4_busy_end", busy_o, 0);

    // 5: capture mid-drain dropped; capture on final transfer chains
    u_if.out_ready_i = 1'b1;
    for (int r = 0; r < ROWS; r++) set_row(r, ACC_BW'(100 + r));
    capture(5'd0);
    for (int r = 0; r < ROWS; r++) exp_q.push_back(mk(r == 7, r, OUT_BW'(100 + r)));
    repeat (3) cycle();
    check_eq("t5_idx3", u_if.out_idx_o, 3);
    for (int r = 0; r < ROWS; r++) set_row(r, 32'h0000_0DEA);
    cap_i = 1'b1;
    cycle();
    cap_i = 1'b0;
    check_eq("t5_ovf", ovf_o, 1);
    repeat (3) cycle();
    check_eq("t5_at_last", u_if.out_last_o, 1);
    for (int r = 0; r < ROWS; r++) set_row(r, ACC_BW'(200 + r));
    for (int r = 0; r < ROWS; r++) exp_q.push_back(mk(r == 7, r, OUT_BW'(200 + r)));
    cap_i = 1'b1;
    cycle();
    cap_i = 1'b0;
    check_eq("t5_nogap_valid", u_if.out_valid_o, 1);
    check_eq("t5_nogap_idx", u_if.out_idx_o, 0);
    check_eq("t5_nogap_data", u_if.out_data_o, 200);
    check_eq("t5_ovf_kept", ovf_o, 1);
    drain("t5", 20, cyc);
    check_eq("t5_cycles", cyc, 8);
    clr_i = 1'b1;
    cycle();
    clr_i = 1'b0;
    check_eq("t5_ovf_clr", ovf_o, 0);

    // 6: reset at idx 5 discards remaining words and flags
    set_row(0, 32'h7FFF_FFFF);
    for (int r = 1; r < ROWS; r++) set_row(r, ACC_BW'(50 + r));
    capture(5'd0);
    exp_q.push_back(mk(0, 0, 16'h7FFF));
    for (int r = 1; r < ROWS; r++) exp_q.push_back(mk(r == 7, r, OUT_BW'(50 + r)));
    repeat (2) cycle();
    cap_i = 1'b1;
    cycle();
    cap_i = 1'b0;
    repeat (2) cycle();
    check_eq("t6_idx5", u_if.out_idx_o, 5);
    check_eq("t6_flags_pre", {ovf_o, sat_o}, 2'b11);
    u_if.out_ready_i = 1'b0;
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    exp_q.delete();
    check_eq("t6_valid", u_if.out_valid_o, 0);
    check_eq("t6_busy", busy_o, 0);
    check_eq("t6_flags", {ovf_o, sat_o}, 0);
    check_eq("t6_idx", u_if.out_idx_o, 0);
    u_if.out_ready_i = 1'b1;
    for (int r = 0; r < ROWS; r++) set_row(r, ACC_BW'(r + 1));
    capture(5'd0);
    for (int r = 0; r < ROWS; r++) exp_q.push_back(mk(r == 7, r, OUT_BW'(r + 1)));
    drain("t6", 20, cyc);
    check_eq("t6_cycles", cyc, 8);
    check_eq("t6_busy_end", busy_o, 0);

    // final report
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
